mac_cluster_seq: RTL and testbench
==================================

Name: mac_cluster_seq

Overview:
Control stage wrapped around mac_cluster. It loads a cluster configuration (mode, accumulate, signed, four initial accumulator values) from a 32-bit word stream and issues the one-cycle cset. It then streams packed operand beats into A0..B3 and drains the cluster pipeline. It captures out0..out3 into a result register and presents it on a valid/ready port, so a host or DMA can drive the cluster without cycle-exact timing.

Parameters:
MAC_CONF_WIDTH, 4, cluster config field width (mode[1:0], acc[2], signed[3]; encodings from mac_const.vh)
MAC_MIN_WIDTH, 8, per-lane operand width
MAC_ACC_WIDTH, 32, per-lane accumulator width (4*MAC_MIN_WIDTH)
MAC_LATENCY, 4, edges from operand accept to final cluster output: operand reg 1, cluster pipe 2, accumulator 1
CNT_WIDTH, 16, operand beat counter width

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
cfg_valid  in  1  config word valid
cfg_ready  out  1  config word accepted
cfg_data  in  32  config word
op_valid  in  1  operand beat valid
op_ready  out  1  operand beat accepted
op_data  in  8*MAC_MIN_WIDTH  {B3,B2,B1,B0,A3,A2,A1,A0}
res_valid  out  1  result valid
res_ready  in  1  result accepted
res_data  out  4*MAC_ACC_WIDTH  {out3,out2,out1,out0}
busy  out  1  not in IDLE
mac_cset  out  1  to cluster cset
mac_en  out  1  to cluster en
mac_cfg  out  4*MAC_ACC_WIDTH+MAC_CONF_WIDTH  to cluster cfg
mac_a0..mac_a3, mac_b0..mac_b3  out  MAC_MIN_WIDTH each  to cluster operands
mac_out0..mac_out3  in  MAC_ACC_WIDTH each  from cluster

Behaviour:
- Reset values: all outputs 0; state IDLE; mac_cfg, result and counters cleared.
- States: IDLE, LOAD, CSET, RUN, DRAIN, RESP.
- IDLE: cfg_ready=1. First accepted word: [3:0] go to the conf field, [31:16] give beat count N. Go to LOAD with word index 1.
- LOAD: cfg_ready=1. Words 1..4 load initial0..initial3 into mac_cfg fields in order. Stalls hold state indefinitely. Accepting word 4 moves to CSET.
- CSET: mac_cset=1 for exactly one cycle, mac_en=0, mac_cfg stable. Next state is RUN; if N==0, go directly to RESP and capture the initial values from mac_cfg.
- mac_cfg holds its value from the end of LOAD until the next IDLE-word accept, because the cluster reads mode continuously.
- RUN: op_ready=1; mac_en = op_valid. On handshake, op_data is registered onto mac_a*/mac_b* and the beat counter increments.
- op_valid=0 in RUN gives mac_en=0, which freezes the whole cluster pipeline; operand regs hold.
- The N-th accept moves to DRAIN with drain counter 0.
- DRAIN: op_ready=0; mac_en=1; operand regs load zeros. The counter increments every cycle. On the edge where the counter reaches MAC_LATENCY-1 (the MAC_LATENCY-th edge after the last accept), mac_out0..3 are sampled into res_data. Move to RESP.
- RESP: res_valid=1, res_data stable until res_ready; mac_en=0. On handshake go to IDLE; res_valid=0 the next cycle.
- cfg_ready=0 and op_ready=0 in every state not listed above.
- Simultaneous cfg_valid during RUN/DRAIN/RESP is ignored (not accepted).
- Reset mid-operation: next edge returns to IDLE and clears everything. No partial config survives, and mac_cset is not issued.
- Beat counter width: N up to 2^CNT_WIDTH-1; no wrap, compare equality only.

Decomposition:
- Package/header mac_seq_pkg: state encoding, config word-field offsets (conf [3:0], count [31:16]), number of config words (5).
- Mode encodings stay in mac_const.vh.
- One natural sub-module: mac_seq_cfg_shift, which assembles the 5-word config into mac_cfg with a word index.
- Everything else is the FSM in the top.

Test Plan:
- Single-lane unsigned accumulate: conf={signed0,acc1,MAC_SINGLE}, initials 0, N=3, every beat A=2,B=3 on all lanes -> res_data lanes each 18; mac_cset high exactly 1 cycle.
- Signed non-accumulate dual: conf={1,0,MAC_DUAL}, N=2, last beat {A1,A0}=0xFFFE (-2), {B1,B0}=0x0003 -> {out1,out0}=0xFFFFFFFA; same for upper pair.
- N=0 with initials 5,6,7,8 -> no mac_en pulses; res_data={8,7,6,5} one cycle after CSET.
- op_valid toggled 1,0,0,1,0,1 during RUN, quad unsigned acc, N=3, A=1,B=1 (only lane0 nonzero) -> out0=3 plus initial; result identical to ungapped run.
- res_ready held low 10 cycles -> res_valid and res_data stable, cfg_ready=0 throughout; accept frees IDLE.
- reset asserted in the LOAD word-3 cycle and in DRAIN -> next cycle busy=0, all outputs 0, subsequent full run correct.

Source files
------------

// File: rtl/mac_seq_pkg.sv
// mac_seq_pkg: sequencer state encoding and config word layout
package mac_seq_pkg;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CSET  = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;
    localparam int CONF_LSB  = 0;
    localparam int COUNT_LSB = 16;
    localparam int CFG_WORDS = 5;
endpackage

// File: rtl/mac_seq_cfg_shift.sv
// mac_seq_cfg_shift: assembles the five config words into the cluster cfg vector
module mac_seq_cfg_shift
    import mac_seq_pkg::*;
#(
    parameter int ACC_W  = 32,
    parameter int CONF_W = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [31:0]               word,
    output logic [4*ACC_W+CONF_W-1:0] cfg,
    output logic                      last
);
    logic [2:0] idx;
    assign last = load && idx == 3'(CFG_WORDS - 1);
    // the first word replaces the whole vector so no stale initials survive
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg <= '0;
            idx <= '0;
        end else if (load) begin
            idx <= last ? '0 : idx + 3'd1;
            if (idx == '0) cfg <= {{(4*ACC_W){1'b0}}, word[CONF_LSB +: CONF_W]};
            else cfg[CONF_W + (int'(idx) - 1) * ACC_W +: ACC_W] <= word[ACC_W-1:0];
        end
    end
endmodule

// File: rtl/mac_cluster_seq.sv
// mac_cluster_seq: loads a cluster config from a word stream, streams operand beats
// into the cluster and returns the drained outputs on a valid/ready port
module mac_cluster_seq
    import mac_seq_pkg::*;
#(
    parameter int MAC_CONF_WIDTH = 4,
    parameter int MAC_MIN_WIDTH  = 8,
    parameter int MAC_ACC_WIDTH  = 32,
    parameter int MAC_LATENCY    = 4,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    cfg_valid,
    output logic                                    cfg_ready,
    input  logic [31:0]                             cfg_data,
    input  logic                                    op_valid,
    output logic                                    op_ready,
    input  logic [8*MAC_MIN_WIDTH-1:0]              op_data,
    output logic                                    res_valid,
    input  logic                                    res_ready,
    output logic [4*MAC_ACC_WIDTH-1:0]              res_data,
    output logic                                    busy,
    output logic                                    mac_cset,
    output logic                                    mac_en,
    output logic [4*MAC_ACC_WIDTH+MAC_CONF_WIDTH-1:0] mac_cfg,
    output logic [MAC_MIN_WIDTH-1:0]                mac_a0,
    output logic [MAC_MIN_WIDTH-1:0]                mac_a1,
    output logic [MAC_MIN_WIDTH-1:0]                mac_a2,
    output logic [MAC_MIN_WIDTH-1:0]                mac_a3,
    output logic [MAC_MIN_WIDTH-1:0]                mac_b0,
    output logic [MAC_MIN_WIDTH-1:0]                mac_b1,
    output logic [MAC_MIN_WIDTH-1:0]                mac_b2,
    output logic [MAC_MIN_WIDTH-1:0]                mac_b3,
    input  logic [MAC_ACC_WIDTH-1:0]                mac_out0,
    input  logic [MAC_ACC_WIDTH-1:0]                mac_out1,
    input  logic [MAC_ACC_WIDTH-1:0]                mac_out2,
    input  logic [MAC_ACC_WIDTH-1:0]                mac_out3
);
    logic [2:0]                 state;
    logic [CNT_WIDTH-1:0]       n;
    logic [CNT_WIDTH-1:0]       cnt;
    logic [CNT_WIDTH-1:0]       cnt_inc;
    logic [8*MAC_MIN_WIDTH-1:0] ops;
    logic                       cfg_acc;
    logic                       cfg_last;

    assign cfg_ready = !reset && (state == S_IDLE || state == S_LOAD);
    assign cfg_acc   = cfg_valid && cfg_ready;
    assign op_ready  = state == S_RUN;
    assign mac_cset  = state == S_CSET;
    // a stalled operand stream freezes the whole cluster pipeline
    assign mac_en    = (state == S_RUN && op_valid) || state == S_DRAIN;
    assign res_valid = state == S_RESP;
    assign busy      = state != S_IDLE;
    assign cnt_inc   = cnt + CNT_WIDTH'(1);
    assign {mac_b3, mac_b2, mac_b1, mac_b0, mac_a3, mac_a2, mac_a1, mac_a0} = ops;

    mac_seq_cfg_shift #(.ACC_W(MAC_ACC_WIDTH), .CONF_W(MAC_CONF_WIDTH)) u_cfg (
        .clk   (clk),
        .reset (reset),
        .load  (cfg_acc),
        .word  (cfg_data),
        .cfg   (mac_cfg),
        .last  (cfg_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            n        <= '0;
            cnt      <= '0;
            ops      <= '0;
            res_data <= '0;
        end else begin
            case (state)
                S_IDLE: if (cfg_acc) begin
                    n     <= cfg_data[COUNT_LSB +: CNT_WIDTH];
                    state <= S_LOAD;
                end
                S_LOAD: if (cfg_last) state <= S_CSET;
                S_CSET: begin
                    cnt   <= '0;
                    state <= n == '0 ? S_RESP : S_RUN;
                    if (n == '0) res_data <= mac_cfg[MAC_CONF_WIDTH +: 4*MAC_ACC_WIDTH];
                end
                S_RUN: if (op_valid) begin
                    ops <= op_data;
                    cnt <= cnt_inc == n ? '0 : cnt_inc;
                    if (cnt_inc == n) state <= S_DRAIN;
                end
                // zeros flush the pipe; capture once the last beat has reached the accumulator
                S_DRAIN: begin
                    ops <= '0;
                    cnt <= cnt_inc;
                    if (cnt == CNT_WIDTH'(MAC_LATENCY - 1)) begin
                        res_data <= {mac_out3, mac_out2, mac_out1, mac_out0};
                        state    <= S_RESP;
                    end
                end
                S_RESP: if (res_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_cluster_seq.sv
// tb_mac_cluster_seq: table-driven runs against a behavioural cluster stand-in,
// with a result scoreboard plus hand-written reset and stall sequences
module tb_mac_cluster_seq;
    logic         clk = 1'b0;
    logic         reset;
    logic         cfg_valid, cfg_ready, op_valid, op_ready, res_valid, res_ready;
    logic [31:0]  cfg_data;
    logic [63:0]  op_data;
    logic [127:0] res_data;
    logic         busy, mac_cset, mac_en;
    logic [131:0] mac_cfg;
    logic [7:0]   mac_a0, mac_a1, mac_a2, mac_a3, mac_b0, mac_b1, mac_b2, mac_b3;
    logic [31:0]  mac_out0, mac_out1, mac_out2, mac_out3;
    logic [329:0] outs;
    logic [127:0] p1, p2, acc;
    logic [127:0] sb[$];
    int total = 0;
    int bad = 0;
    int cset_cnt = 0;
    int en_cnt = 0;

    typedef struct {
        string        name;
        logic [3:0]   conf;
        int           n;
        logic [127:0] init;
        logic [63:0]  op;
        logic [7:0]   gaps;
        int           stall;
        logic [127:0] exp;
    } vec_t;
    vec_t vecs[7];

    always #5 clk = ~clk;

    mac_cluster_seq dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
        .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .mac_cset(mac_cset), .mac_en(mac_en), .mac_cfg(mac_cfg),
        .mac_a0(mac_a0), .mac_a1(mac_a1), .mac_a2(mac_a2), .mac_a3(mac_a3),
        .mac_b0(mac_b0), .mac_b1(mac_b1), .mac_b2(mac_b2), .mac_b3(mac_b3),
        .mac_out0(mac_out0), .mac_out1(mac_out1), .mac_out2(mac_out2), .mac_out3(mac_out3)
    );

    assign outs = {cfg_ready, op_ready, res_valid, res_data, busy, mac_cset, mac_en, mac_cfg,
                   mac_a0, mac_a1, mac_a2, mac_a3, mac_b0, mac_b1, mac_b2, mac_b3};

    // w-bit multiply, operands optionally sign-extended, low 32 bits kept
    function automatic logic [31:0] mulx(input logic [31:0] a, input logic [31:0] b, input int w, input logic s);
        longint x, y;
        x = longint'(a);
        y = longint'(b);
        if (s && a[w-1]) x -= longint'(1) << w;
        if (s && b[w-1]) y -= longint'(1) << w;
        return 32'(x * y);
    endfunction

    // cluster stand-in: mode 0 four 8x8 lanes, mode 1 two 16x16 into out0/out2, mode 2 one 32x32 into out0
    function automatic logic [127:0] prod(input logic [63:0] o, input logic [3:0] c);
        logic [127:0] r;
        r = '0;
        case (c[1:0])
            2'd1: begin
                r[31:0]  = mulx(32'(o[15:0]), 32'(o[47:32]), 16, c[3]);
                r[95:64] = mulx(32'(o[31:16]), 32'(o[63:48]), 16, c[3]);
            end
            2'd2: r[31:0] = mulx(o[31:0], o[63:32], 32, c[3]);
            default: for (int i = 0; i < 4; i++) r[32*i +: 32] = mulx(32'(o[8*i +: 8]), 32'(o[32+8*i +: 8]), 8, c[3]);
        endcase
        return r;
    endfunction

    // operand reg lives in the DUT; pipe p1, p2 then accumulator give four edges in total
    always @(posedge clk) begin
        if (reset) begin
            p1 <= '0;
            p2 <= '0;
            acc <= '0;
        end else if (mac_cset) begin
            acc <= mac_cfg[131:4];
        end else if (mac_en) begin
            p1 <= prod({mac_b3, mac_b2, mac_b1, mac_b0, mac_a3, mac_a2, mac_a1, mac_a0}, mac_cfg[3:0]);
            p2 <= p1;
            for (int i = 0; i < 4; i++) acc[32*i +: 32] <= (mac_cfg[2] ? acc[32*i +: 32] : 32'd0) + p2[32*i +: 32];
        end
        cset_cnt <= cset_cnt + int'(mac_cset);
        en_cnt <= en_cnt + int'(mac_en);
    end
    assign {mac_out3, mac_out2, mac_out1, mac_out0} = acc;

    function automatic void chk(input string nm, input logic [329:0] act, input logic [329:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endfunction

    task automatic send_cfg(input logic [31:0] w);
        int t;
        t = 0;
        cfg_valid = 1'b1;
        cfg_data = w;
        while (!cfg_ready && t < 100) begin @(negedge clk); t++; end
        chk("cfg_handshake", cfg_ready, 1);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic send_op(input logic [63:0] d);
        int t;
        t = 0;
        op_valid = 1'b1;
        op_data = d;
        while (!op_ready && t < 100) begin @(negedge clk); t++; end
        chk("op_handshake", op_ready, 1);
        @(negedge clk);
        op_valid = 1'b0;
        op_data = '0;
    endtask

    task automatic start(input vec_t v);
        send_cfg({16'(v.n), 12'h0, v.conf});
        for (int k = 0; k < 4; k++) send_cfg(v.init[32*k +: 32]);
        for (int k = 0; k < v.n; k++) begin
            repeat (k < 4 ? int'(v.gaps[2*k +: 2]) : 0) @(negedge clk);
            send_op(v.op);
        end
    endtask

    task automatic run(input vec_t v);
        int c0, e0, t;
        logic [127:0] got;
        c0 = cset_cnt;
        e0 = en_cnt;
        sb.push_back(v.exp);
        start(v);
        t = 0;
        while (!res_valid && t < 50) begin @(negedge clk); t++; end
        chk({v.name, "_latency"}, 330'(t), 330'(v.n == 0 ? 1 : 4));
        for (int k = 0; k < v.stall; k++) begin
            cfg_valid = 1'b1;
            cfg_data = 32'hDEAD0003;
            chk({v.name, "_stall_valid"}, res_valid, 1);
            chk({v.name, "_stall_data"}, res_data, v.exp);
            chk({v.name, "_stall_cfg_ready"}, cfg_ready, 0);
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        chk({v.name, "_cfg_hold"}, mac_cfg, {v.init, v.conf});
        got = res_data;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({v.name, "_result"}, got, sb.pop_front());
        chk({v.name, "_released"}, {res_valid, busy, cfg_ready}, 3'b001);
        chk({v.name, "_cset_pulses"}, 330'(cset_cnt - c0), 1);
        chk({v.name, "_en_pulses"}, 330'(en_cnt - e0), 330'(v.n == 0 ? 0 : v.n + 4));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int c0;
        reset = 1'b1;
        cfg_valid = 1'b0;
        cfg_data = '0;
        op_valid = 1'b0;
        op_data = '0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", outs, '0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_cfg_ready", {cfg_ready, busy}, 2'b10);

        vecs[0] = '{"single_acc", 4'h4, 3, 128'h0, 64'h03030303_02020202, 8'h00, 10, {4{32'd18}}};
        vecs[1] = '{"dual_signed", 4'h9, 2, 128'h0, 64'h00030003_FFFEFFFE, 8'h00, 0,
                    {32'd0, 32'hFFFFFFFA, 32'd0, 32'hFFFFFFFA}};
        vecs[2] = '{"zero_beats", 4'h4, 0, {32'd8, 32'd7, 32'd6, 32'd5}, 64'h01010101_01010101, 8'h00, 0,
                    {32'd8, 32'd7, 32'd6, 32'd5}};
        vecs[3] = '{"quad_gap", 4'h6, 3, {32'd40, 32'd30, 32'd20, 32'd10}, 64'h00000001_00000001, 8'h18, 0,
                    {32'd40, 32'd30, 32'd20, 32'd13}};
        vecs[4] = '{"quad_nogap", 4'h6, 3, {32'd40, 32'd30, 32'd20, 32'd10}, 64'h00000001_00000001, 8'h00, 0,
                    {32'd40, 32'd30, 32'd20, 32'd13}};
        vecs[5] = '{"single_signed", 4'hC, 4, {32'd0, 32'd0, 32'd0, 32'd100}, 64'h05050505_FFFFFFFF, 8'h00, 2,
                    {32'hFFFFFFEC, 32'hFFFFFFEC, 32'hFFFFFFEC, 32'd80}};
        vecs[6] = '{"single_one", 4'h0, 1, {32'd4, 32'd3, 32'd2, 32'd1}, 64'hFFFFFFFF_FFFFFFFF, 8'h00, 0,
                    {4{32'h0000FE01}}};
        for (int i = 0; i < 7; i++) run(vecs[i]);

        // reset arriving with config word 3 on the bus
        c0 = cset_cnt;
        send_cfg(32'h0003_0004);
        send_cfg(32'd1);
        send_cfg(32'd2);
        cfg_valid = 1'b1;
        cfg_data = 32'd3;
        reset = 1'b1;
        @(negedge clk);
        chk("reset_in_load", outs, '0);
        reset = 1'b0;
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("reset_in_load_idle", {cfg_ready, busy, mac_cset}, 3'b100);
        chk("reset_in_load_no_cset", 330'(cset_cnt - c0), 0);
        run(vecs[0]);

        // reset while draining
        start(vecs[3]);
        chk("drain_reached", {busy, op_ready, mac_en}, 3'b101);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_in_drain", outs, '0);
        reset = 1'b0;
        @(negedge clk);
        run(vecs[3]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
